// File: rtl/wb_pkg.sv
`default_nettype none
// ------------------------------------------------------------
// wb_pkg: shared writeback widths and entry record
// Rev 1.0
// ------------------------------------------------------------
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ------------------------------------------------------------
// wb_fifo: per-lane result FIFO exporting entry-valid bits and tags
// Rev 1.0
// ------------------------------------------------------------
module wb_fifo #(
  parameter int WIDTH = 21,
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            push_i,
  input  logic [WIDTH-1:0]                pushData_i,
  input  logic                            pop_i,
  output logic [WIDTH-1:0]                headData_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [DEPTH-1:0]                entryValid_o,
  output logic [DEPTH-1:0][TAG_W-1:0]     entryTags_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PTR_W-1:0]            r_rdPtr;
  logic [PTR_W-1:0]            r_wrPtr;
  logic [PTR_W:0]              r_count;
  logic                        w_push;
  logic                        w_pop;

  assign full_o     = (r_count == (PTR_W+1)'(DEPTH));
  assign empty_o    = (r_count == '0);
  assign w_push     = push_i && !full_o;
  assign w_pop      = pop_i && !empty_o;
  assign headData_o = r_mem[r_rdPtr];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage carries no reset; stale slots are masked by entryValid_o.
  always_ff @(posedge clock_i) begin
    if (w_push) r_mem[r_wrPtr] <= pushData_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0] w_offset;
    assign w_offset        = PTR_W'(i) - r_rdPtr;
    assign entryValid_o[i] = ({1'b0, w_offset} < r_count);
    assign entryTags_o[i]  = r_mem[i][WIDTH-1 -: TAG_W];
  end

endmodule
`default_nettype wire

// File: rtl/writeback_controller.sv
`default_nettype none
// ------------------------------------------------------------
// writeback_controller: two-lane result collection and ordered writeback
// Rev 1.0
// ------------------------------------------------------------
module writeback_controller #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     resValidA_i,
  input  logic                     resValidB_i,
  input  logic                     resWbA_i,
  input  logic                     resWbB_i,
  input  logic [ADDR_W-1:0]        resAddrA_i,
  input  logic [ADDR_W-1:0]        resAddrB_i,
  input  logic [DATA_W-1:0]        resValA_i,
  input  logic [DATA_W-1:0]        resValB_i,
  output logic                     resReadyA_o,
  output logic                     resReadyB_o,
  output logic                     wbA_o,
  output logic                     wbB_o,
  output logic [ADDR_W-1:0]        wbAddrA_o,
  output logic [ADDR_W-1:0]        wbAddrB_o,
  output logic [DATA_W-1:0]        wbValA_o,
  output logic [DATA_W-1:0]        wbValB_o,
  output logic [(2**ADDR_W)-1:0]   pendingMask_o
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int REGS    = 2**ADDR_W;

  localparam logic [0:0] ARB_FAIR   = 1'b0;
  localparam logic [0:0] ARB_BFIRST = 1'b1;

  logic [ENTRY_W-1:0]             w_headA, w_headB;
  logic                           w_fullA, w_fullB, w_emptyA, w_emptyB;
  logic [DEPTH-1:0]               w_validA, w_validB;
  logic [DEPTH-1:0][ADDR_W-1:0]   w_tagsA, w_tagsB;
  logic                           w_pushA, w_pushB, w_popA, w_popB;
  logic                           w_collide;
  logic [0:0]                     r_arbState, w_arbNext;
  logic                           r_wbA, r_wbB;
  logic [ADDR_W-1:0]              r_wbAddrA, r_wbAddrB;
  logic [DATA_W-1:0]              r_wbValA, r_wbValB;
  logic [REGS-1:0]                w_mask;

  // Non-writeback results are consumed here and never reach a FIFO.
  assign w_pushA = resValidA_i && resWbA_i && !w_fullA;
  assign w_pushB = resValidB_i && resWbB_i && !w_fullB;

  wb_fifo #(.WIDTH(ENTRY_W), .TAG_W(ADDR_W), .DEPTH(DEPTH)) u_fifoA (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .push_i       (w_pushA),
    .pushData_i   ({resAddrA_i, resValA_i}),
    .pop_i        (w_popA),
    .headData_o   (w_headA),
    .full_o       (w_fullA),
    .empty_o      (w_emptyA),
    .entryValid_o (w_validA),
    .entryTags_o  (w_tagsA)
  );

  wb_fifo #(.WIDTH(ENTRY_W), .TAG_W(ADDR_W), .DEPTH(DEPTH)) u_fifoB (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .push_i       (w_pushB),
    .pushData_i   ({resAddrB_i, resValB_i}),
    .pop_i        (w_popB),
    .headData_o   (w_headB),
    .full_o       (w_fullB),
    .empty_o      (w_emptyB),
    .entryValid_o (w_validB),
    .entryTags_o  (w_tagsB)
  );

  assign w_collide = !w_emptyA && !w_emptyB &&
                     (w_headA[ENTRY_W-1 -: ADDR_W] == w_headB[ENTRY_W-1 -: ADDR_W]);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) r_arbState <= ARB_FAIR;
    else          r_arbState <= w_arbNext;
  end

  always_comb begin
    w_arbNext = r_arbState;
    if (r_arbState == ARB_FAIR) begin
      if (w_collide) w_arbNext = ARB_BFIRST;
    end else begin
      if (w_popB) w_arbNext = ARB_FAIR;
    end
  end

  // Lane A is older by default; after holding B once, B goes first.
  always_comb begin
    w_popA = !w_emptyA;
    w_popB = !w_emptyB;
    if (w_collide) begin
      if (r_arbState == ARB_BFIRST) w_popA = 1'b0;
      else                          w_popB = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wbA     <= 1'b0;
      r_wbB     <= 1'b0;
      r_wbAddrA <= '0;
      r_wbAddrB <= '0;
      r_wbValA  <= '0;
      r_wbValB  <= '0;
    end else begin
      r_wbA <= w_popA;
      r_wbB <= w_popB;
      if (w_popA) begin
        r_wbAddrA <= w_headA[ENTRY_W-1 -: ADDR_W];
        r_wbValA  <= w_headA[DATA_W-1:0];
      end
      if (w_popB) begin
        r_wbAddrB <= w_headB[ENTRY_W-1 -: ADDR_W];
        r_wbValB  <= w_headB[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_validA[i]) w_mask[w_tagsA[i]] = 1'b1;
      if (w_validB[i]) w_mask[w_tagsB[i]] = 1'b1;
    end
    if (r_wbA) w_mask[r_wbAddrA] = 1'b1;
    if (r_wbB) w_mask[r_wbAddrB] = 1'b1;
  end

  assign resReadyA_o   = !w_fullA;
  assign resReadyB_o   = !w_fullB;
  assign wbA_o         = r_wbA;
  assign wbB_o         = r_wbB;
  assign wbAddrA_o     = r_wbAddrA;
  assign wbAddrB_o     = r_wbAddrB;
  assign wbValA_o      = r_wbValA;
  assign wbValB_o      = r_wbValB;
  assign pendingMask_o = w_mask;

endmodule
`default_nettype wire

// File: tb/tb_writeback_controller.sv
`default_nettype none
// ------------------------------------------------------------
// tb_writeback_controller: vector table plus scoreboard bench
// Rev 1.0
// ------------------------------------------------------------
module tb_writeback_controller;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int REGS  = 2**ADDR_W;

  logic clock = 1'b0;
  logic reset_n;
  logic rvA, rvB, rwA, rwB;
  logic [ADDR_W-1:0] raA, raB;
  logic [DATA_W-1:0] rdA, rdB;
  logic readyA, readyB, wbA, wbB;
  logic [ADDR_W-1:0] wbAddrA, wbAddrB;
  logic [DATA_W-1:0] wbValA, wbValB;
  logic [REGS-1:0] mask;

  int nChecks = 0;
  int nFails  = 0;
  int accA = 0, accB = 0, popCntA = 0, popCntB = 0;
  wb_entry_t expA[$];
  wb_entry_t expB[$];
  wb_entry_t monEntry;

  typedef struct {
    logic vA, wA; logic [ADDR_W-1:0] aA; logic [DATA_W-1:0] dA;
    logic vB, wB; logic [ADDR_W-1:0] aB; logic [DATA_W-1:0] dB;
    logic [31:0] mask0;
    logic [1:0]  out1, out2;
  } vec_t;
  vec_t vecs[8];

  always #5 clock = ~clock;

  writeback_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock_i(clock), .reset_i(reset_n),
    .resValidA_i(rvA), .resValidB_i(rvB), .resWbA_i(rwA), .resWbB_i(rwB),
    .resAddrA_i(raA), .resAddrB_i(raB), .resValA_i(rdA), .resValB_i(rdB),
    .resReadyA_o(readyA), .resReadyB_o(readyB), .wbA_o(wbA), .wbB_o(wbB),
    .wbAddrA_o(wbAddrA), .wbAddrB_o(wbAddrB), .wbValA_o(wbValA), .wbValB_o(wbValB),
    .pendingMask_o(mask)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic driveA(input logic v, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_entry_t e;
    rvA = v; rwA = w; raA = a; rdA = d;
    if (v && w && readyA) begin
      e.addr = a; e.val = d;
      expA.push_back(e);
      accA++;
    end
  endtask

  task automatic driveB(input logic v, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_entry_t e;
    rvB = v; rwB = w; raB = a; rdB = d;
    if (v && w && readyB) begin
      e.addr = a; e.val = d;
      expB.push_back(e);
      accB++;
    end
  endtask

  task automatic idle();
    driveA(1'b0, 1'b0, '0, '0);
    driveB(1'b0, 1'b0, '0, '0);
  endtask

  // Scoreboard: every writeback must match the oldest expected entry of its lane.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (wbA) begin
        check("laneA expected entry present", expA.size() != 0, 1);
        if (expA.size() != 0) begin
          monEntry = expA.pop_front();
          check("laneA addr", wbAddrA, monEntry.addr);
          check("laneA val", wbValA, monEntry.val);
        end
        popCntA++;
      end
      if (wbB) begin
        check("laneB expected entry present", expB.size() != 0, 1);
        if (expB.size() != 0) begin
          monEntry = expB.pop_front();
          check("laneB addr", wbAddrB, monEntry.addr);
          check("laneB val", wbValB, monEntry.val);
        end
        popCntB++;
      end
      if (wbA && wbB) check("no same-address output pair", wbAddrA == wbAddrB, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int budget, sent, occB, base;
    bit sawLow;

    vecs[0] = '{1'b1, 1'b1, 5'd3,  16'h1234, 1'b0, 1'b0, 5'd0,  16'h0000, 32'h0000_0008, 2'b10, 2'b00};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  16'h0000, 1'b1, 1'b1, 5'd4,  16'hBEEF, 32'h0000_0010, 2'b01, 2'b00};
    vecs[2] = '{1'b1, 1'b1, 5'd5,  16'h0555, 1'b1, 1'b1, 5'd6,  16'h0666, 32'h0000_0060, 2'b11, 2'b00};
    vecs[3] = '{1'b1, 1'b1, 5'd7,  16'h0001, 1'b1, 1'b1, 5'd7,  16'h0002, 32'h0000_0080, 2'b10, 2'b01};
    vecs[4] = '{1'b1, 1'b0, 5'd9,  16'h0999, 1'b0, 1'b0, 5'd0,  16'h0000, 32'h0000_0000, 2'b00, 2'b00};
    vecs[5] = '{1'b1, 1'b0, 5'd9,  16'h0909, 1'b1, 1'b0, 5'd9,  16'h9090, 32'h0000_0000, 2'b00, 2'b00};
    vecs[6] = '{1'b1, 1'b1, 5'd2,  16'hAAAA, 1'b1, 1'b0, 5'd2,  16'h5555, 32'h0000_0004, 2'b10, 2'b00};
    vecs[7] = '{1'b1, 1'b1, 5'd31, 16'hFFFF, 1'b1, 1'b1, 5'd0,  16'h0000, 32'h8000_0001, 2'b11, 2'b00};

    reset_n = 1'b0;
    idle();
    step(); step();
    check("reset wbA", wbA, 0);
    check("reset wbB", wbB, 0);
    check("reset wbAddrA", wbAddrA, 0);
    check("reset wbAddrB", wbAddrB, 0);
    check("reset wbValA", wbValA, 0);
    check("reset wbValB", wbValB, 0);
    check("reset mask", mask, 0);
    check("reset readyA", readyA, 1);
    check("reset readyB", readyB, 1);
    reset_n = 1'b1;
    step();

    // Single-cycle vectors from an idle, drained state.
    for (int i = 0; i < 8; i++) begin
      driveA(vecs[i].vA, vecs[i].wA, vecs[i].aA, vecs[i].dA);
      driveB(vecs[i].vB, vecs[i].wB, vecs[i].aB, vecs[i].dB);
      step();
      idle();
      check($sformatf("vec%0d mask after accept", i), mask, vecs[i].mask0);
      check($sformatf("vec%0d wb after accept", i), {wbA, wbB}, 2'b00);
      step();
      check($sformatf("vec%0d wb cycle1", i), {wbA, wbB}, vecs[i].out1);
      check($sformatf("vec%0d mask cycle1", i), mask, vecs[i].mask0);
      step();
      check($sformatf("vec%0d wb cycle2", i), {wbA, wbB}, vecs[i].out2);
      step();
      check($sformatf("vec%0d idle wb", i), {wbA, wbB}, 2'b00);
      check($sformatf("vec%0d idle mask", i), mask, 0);
    end

    // Backpressure: lane A keeps colliding on address 10 so lane B drains slowly.
    budget = 0; sent = 0; sawLow = 1'b0;
    while (!(sawLow && sent >= 5) && budget < 60) begin
      occB = accB - popCntB;
      check("readyB tracks occupancy", readyB, occB < DEPTH);
      if (!readyB) sawLow = 1'b1;
      if (readyB && !sawLow) sent++;
      driveB(!sawLow, 1'b1, 5'd10, 16'hB000 + 16'(sent));
      driveA(1'b1, 1'b1, 5'd10, 16'hA000 + 16'(budget));
      step();
      budget++;
    end
    check("readyB went low under backpressure", sawLow, 1);
    idle();
    budget = 0;
    while ((expA.size() != 0 || expB.size() != 0) && budget < 60) begin
      step();
      budget++;
    end
    check("backpressure drain complete", expA.size() + expB.size(), 0);
    step(); step();

    // Reset with entries still queued.
    for (int i = 0; i < 3; i++) begin
      driveA(1'b1, 1'b1, 5'd12, 16'hC000 + 16'(i));
      driveB(1'b1, 1'b1, 5'd12, 16'hD000 + 16'(i));
      step();
    end
    idle();
    check("entries queued before reset", (expA.size() + expB.size()) >= 3, 1);
    #1 reset_n = 1'b0;
    #1;
    check("midreset wbA", wbA, 0);
    check("midreset wbB", wbB, 0);
    check("midreset addr/val", {wbAddrA, wbAddrB, wbValA[7:0], wbValB[7:0]}, 0);
    check("midreset mask", mask, 0);
    check("midreset ready", {readyA, readyB}, 2'b11);
    expA.delete();
    expB.delete();
    step();
    reset_n = 1'b1;
    base = popCntA + popCntB;
    repeat (8) step();
    check("no writes after reset", popCntA + popCntB - base, 0);

    // Back-to-back traffic across several pointer wraps.
    base = popCntA;
    for (int i = 0; i < 19; i++) begin
      check($sformatf("wrap wbA i=%0d", i), wbA, (i >= 2 && i <= 17));
      check($sformatf("wrap wbB i=%0d", i), wbB, (i >= 2 && i <= 17));
      if (i < 16) begin
        driveA(1'b1, 1'b1, ADDR_W'(i), 16'h1000 + 16'(i));
        driveB(1'b1, 1'b1, ADDR_W'(16 + i), 16'h2000 + 16'(i));
      end else begin
        idle();
      end
      step();
    end
    check("wrap laneA write count", popCntA - base, 16);
    check("wrap queues empty", expA.size() + expB.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
